// File: rtl/hazard_unit.sv
// Stall/forward control for a 5-stage pipeline using Tuse/Tnew tracking.
// Optional `HAZARD_STALL_CNT_EN adds a free-running stall cycle counter.
module hazard_unit #(
  parameter int TMAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [3:0] D_Tuse_rs,
  input  logic [3:0] D_Tuse_rt,
  input  logic [4:0] D_A3,
  input  logic [3:0] D_Tnew,
  output logic       stall,
  output logic       PC_en,
  output logic       D_en,
  output logic       E_clr,
  output logic [1:0] FwdD_rs,
  output logic [1:0] FwdD_rt,
  output logic [1:0] FwdE_rs,
  output logic [1:0] FwdE_rt
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [3:0] TNONE = TMAX[3:0];

  typedef struct packed {
    logic [4:0] a3;
    logic [3:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } e_rec_t;

  typedef struct packed {
    logic [4:0] a3;
    logic [3:0] tnew;
  } rec_t;

  e_rec_t e_q;
  rec_t   m_q;
  rec_t   w_q;

  function automatic logic [3:0] dec(
    input logic [3:0] t
  );
    return (t == 4'd0) ? 4'd0 : t - 4'd1;
  endfunction

  function automatic logic hit(
    input logic [4:0] a3,
    input logic [4:0] r
  );
    return (r != 5'd0) && (a3 == r);
  endfunction

  function automatic logic late(
    input logic [4:0] a3,
    input logic [3:0] tnew,
    input logic [4:0] r,
    input logic [3:0] tuse
  );
    return hit(a3, r) && (tnew > tuse) &&
           (tuse != TNONE);
  endfunction

  function automatic logic [1:0] fwd_d(
    input e_rec_t     e,
    input rec_t       m,
    input rec_t       w,
    input logic [4:0] r
  );
    logic [1:0] f;
    f = 2'd0;
    if (hit(e.a3, r))
      f = (e.tnew == 4'd0) ? 2'd1 : 2'd0;
    else if (hit(m.a3, r))
      f = (m.tnew == 4'd0) ? 2'd2 : 2'd0;
    else if (hit(w.a3, r))
      f = (w.tnew == 4'd0) ? 2'd3 : 2'd0;
    return f;
  endfunction

  function automatic logic [1:0] fwd_e(
    input rec_t       m,
    input rec_t       w,
    input logic [4:0] r
  );
    logic [1:0] f;
    f = 2'd0;
    if (hit(m.a3, r))
      f = (m.tnew == 4'd0) ? 2'd1 : 2'd0;
    else if (hit(w.a3, r))
      f = (w.tnew == 4'd0) ? 2'd2 : 2'd0;
    return f;
  endfunction

  always_comb begin
    stall = late(e_q.a3, e_q.tnew, D_rs, D_Tuse_rs)
          | late(m_q.a3, m_q.tnew, D_rs, D_Tuse_rs)
          | late(e_q.a3, e_q.tnew, D_rt, D_Tuse_rt)
          | late(m_q.a3, m_q.tnew, D_rt, D_Tuse_rt);
    PC_en   = ~stall;
    D_en    = ~stall;
    E_clr   = stall;
    FwdD_rs = fwd_d(e_q, m_q, w_q, D_rs);
    FwdD_rt = fwd_d(e_q, m_q, w_q, D_rt);
    FwdE_rs = fwd_e(m_q, w_q, e_q.rs);
    FwdE_rt = fwd_e(m_q, w_q, e_q.rt);
  end

  // A stall drops a bubble into E; M and W always advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      if (stall)
        e_q <= '0;
      else
        e_q <= '{a3: D_A3, tnew: dec(D_Tnew),
                 rs: D_rs, rt: D_rt};
      m_q <= '{a3: e_q.a3, tnew: dec(e_q.tnew)};
      w_q <= '{a3: m_q.a3, tnew: dec(m_q.tnew)};
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: scoreboarded stall/forward expectations.
// Stall counter checks compile in with HAZARD_STALL_CNT_EN.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] D_rs, D_rt, D_A3;
  logic [3:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
  logic       stall, PC_en, D_en, E_clr;
  logic [1:0] FwdD_rs, FwdD_rt, FwdE_rs, FwdE_rt;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  typedef struct {
    logic       st;
    logic [1:0] fdrs;
    logic [1:0] fdrt;
    logic [1:0] fers;
    logic [1:0] fert;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  hazard_unit dut (
    .clk       (clk),
    .reset     (reset),
    .D_rs      (D_rs),
    .D_rt      (D_rt),
    .D_Tuse_rs (D_Tuse_rs),
    .D_Tuse_rt (D_Tuse_rt),
    .D_A3      (D_A3),
    .D_Tnew    (D_Tnew),
    .stall     (stall),
    .PC_en     (PC_en),
    .D_en      (D_en),
    .E_clr     (E_clr),
    .FwdD_rs   (FwdD_rs),
    .FwdD_rt   (FwdD_rt),
    .FwdE_rs   (FwdE_rs),
    .FwdE_rt   (FwdE_rt)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic step(
    input string      tag,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [3:0] tu_rs,
    input logic [3:0] tu_rt,
    input logic [4:0] a3,
    input logic [3:0] tnew,
    input logic       st,
    input logic [1:0] fdrs,
    input logic [1:0] fdrt,
    input logic [1:0] fers,
    input logic [1:0] fert
  );
    exp_t e;
    logic nst;
    D_rs = rs;
    D_rt = rt;
    D_Tuse_rs = tu_rs;
    D_Tuse_rt = tu_rt;
    D_A3 = a3;
    D_Tnew = tnew;
    e.st = st;
    e.fdrs = fdrs;
    e.fdrt = fdrt;
    e.fers = fers;
    e.fert = fert;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    nst = ~e.st;
    chk({tag, ".stall"}, 32'(stall), 32'(e.st));
    chk({tag, ".PC_en"}, 32'(PC_en), 32'(nst));
    chk({tag, ".D_en"}, 32'(D_en), 32'(nst));
    chk({tag, ".E_clr"}, 32'(E_clr), 32'(e.st));
    chk({tag, ".FwdD_rs"}, 32'(FwdD_rs), 32'(e.fdrs));
    chk({tag, ".FwdD_rt"}, 32'(FwdD_rt), 32'(e.fdrt));
    chk({tag, ".FwdE_rs"}, 32'(FwdE_rs), 32'(e.fers));
    chk({tag, ".FwdE_rt"}, 32'(FwdE_rt), 32'(e.fert));
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input string tag, input logic [1:0] fers,
                     input logic [1:0] fert);
    step(tag, 0, 0, 15, 15, 0, 0, 0, 0, 0, fers, fert);
  endtask

  initial begin
    D_rs = 0; D_rt = 0; D_A3 = 0;
    D_Tuse_rs = 15; D_Tuse_rt = 15; D_Tnew = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state with arbitrary D reads
    step("rst_a", 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop("rst_b", 0, 0);

    // lw $1 ; add $2,$1,$3 ; then W->E and M->D forwards
    step("lu_lw", 3, 0, 1, 15, 1, 3, 0, 0, 0, 0, 0);
    step("lu_stall", 1, 3, 1, 1, 2, 2, 1, 0, 0, 0, 0);
    step("lu_go", 1, 3, 1, 1, 2, 2, 0, 0, 0, 0, 0);
    nop("lu_fe_w", 2, 0);
    step("lu_fd_m", 2, 0, 1, 15, 0, 0, 0, 2, 0, 0, 0);
    nop("lu_fe_w2", 2, 0);

    // add $1 ; beq $1,$0
    step("cb_add", 0, 0, 15, 15, 1, 2, 0, 0, 0, 0, 0);
    step("cb_stall", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("cb_fd_m", 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    nop("cb_fe_w", 2, 0);

    // lw $4 ; beq $5,$4 : two stalls, then W forward
    step("lb_lw", 0, 0, 15, 15, 4, 3, 0, 0, 0, 0, 0);
    step("lb_st1", 5, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("lb_st2", 5, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("lb_fd_w", 5, 4, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    nop("lb_idle", 0, 0);

    // $1 ready in both E and M: E wins, then M->E
    step("pr_m", 0, 0, 15, 15, 1, 2, 0, 0, 0, 0, 0);
    step("pr_e", 0, 0, 15, 15, 1, 1, 0, 0, 0, 0, 0);
    step("pr_fd_e", 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    nop("pr_fe_m", 1, 1);
    nop("pr_idle", 0, 0);

    // Writes to $0 never hazard
    step("z_wr", 0, 0, 15, 15, 0, 2, 0, 0, 0, 0, 0);
    step("z_rd", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Tuse=TMAX never stalls, and pending Tnew blocks forwards
    step("tm_lw", 0, 0, 15, 15, 6, 3, 0, 0, 0, 0, 0);
    step("tm_rd", 6, 6, 15, 15, 0, 0, 0, 0, 0, 0, 0);
    nop("tm_fe", 0, 0);
    nop("tm_idle", 0, 0);

    // Reset while stalled
    step("rs_lw", 0, 0, 15, 15, 1, 3, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step("rs_stall", 1, 0, 1, 15, 2, 2, 1, 0, 0, 0, 0);
    reset = 1'b0;
    step("rs_after", 1, 0, 1, 15, 2, 2, 0, 0, 0, 0, 0);
`ifdef HAZARD_STALL_CNT_EN
    chk("rs_cnt", stall_cnt, 32'd0);
`endif
    nop("rs_n1", 0, 0);
    nop("rs_n2", 0, 0);
    nop("rs_n3", 0, 0);

    // Three back-to-back load-use pairs
    for (int i = 0; i < 3; i++) begin
      step("bb_lw", 0, 0, 15, 15, 1, 3, 0, 0, 0, 0, 0);
      step("bb_st", 1, 0, 1, 15, 2, 2, 1, 0, 0, 0, 0);
      step("bb_go", 1, 0, 1, 15, 2, 2, 0, 0, 0, 0, 0);
      nop("bb_fe", 2, 0);
    end
`ifdef HAZARD_STALL_CNT_EN
    chk("bb_cnt", stall_cnt, 32'd3);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
